// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   CTR_*        2-bit saturating counter encodings (00 strong-NT .. 11 strong-T)
//   CTR_RST      counter value loaded into every entry on reset
//   CTR_ALLOC    counter value given to a freshly allocated entry
//   tag_width()  tag bits left after removing index and byte-offset bits
package bp_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RST   = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   function automatic int tag_width(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

endpackage

// File: rtl/sat_counter_2bit.sv
// Next-state logic of a 2-bit saturating direction counter.
//   ctr      current counter value
//   taken    resolved branch outcome
//   ctr_nxt  counter after training (saturates at CTR_SNT / CTR_ST)
module sat_counter_2bit
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_nxt
);

   always_comb begin
      ctr_nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the IF stage.
//   clk, rst           clock, synchronous active-low reset
//   fetch_pc           PC in IF; pred_taken/pred_target are combinational on it
//   upd_*              resolved conditional branch from EX (trains the BTB)
//   upd_pred_*         prediction originally made for that branch
//   mispredict         resolved branch was predicted wrong (combinational)
//   redirect_pc        correct next PC when mispredict=1, else 0
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = tag_width(XLEN, ENTRIES);

   // Entry storage in flops: every entry must be cleared by reset.
   logic [ENTRIES-1:0]            valid_q;
   logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
   logic [ENTRIES-1:0][XLEN-1:0]  tgt_q;
   logic [ENTRIES-1:0][1:0]       ctr_q;

   // Byte-offset bits never take part in indexing or tagging.
   logic unused_ok;
   assign unused_ok = ^{fetch_pc[1:0], upd_pc[1:0]};

   // ---- lookup ----
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   assign pred_taken  = f_hit && ctr_q[f_idx][1];
   assign pred_target = pred_taken ? tgt_q[f_idx] : '0;

   // ---- update ----
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [1:0]       ctr_nxt;

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[XLEN-1:IDX_W+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   sat_counter_2bit u_ctr (
      .ctr     (ctr_q[u_idx]),
      .taken   (upd_taken),
      .ctr_nxt (ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         tag_q   <= '0;
         tgt_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
      end else if (upd_valid) begin
         if (u_hit) begin
            ctr_q[u_idx] <= ctr_nxt;
            if (upd_taken) tgt_q[u_idx] <= upd_target;
         end else if (upd_taken) begin
            // Taken miss replaces whatever lives at this index; not-taken never evicts.
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= upd_target;
            ctr_q[u_idx]   <= CTR_ALLOC;
         end
      end
   end

   // ---- mispredict / redirect (update inputs only, gated by reset) ----
   logic dir_wrong, tgt_wrong;

   assign dir_wrong   = upd_taken != upd_pred_taken;
   assign tgt_wrong   = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
   assign mispredict  = rst && upd_valid && (dir_wrong || tgt_wrong);
   assign redirect_pc = !mispredict ? '0 :
                        upd_taken   ? upd_target : upd_pc + XLEN'(4);

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 16;
   localparam int IDX_W   = $clog2(ENTRIES);

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] fetch_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic            upd_pred_taken;
   logic [XLEN-1:0] upd_pred_target;
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;

   branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_pc        (fetch_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: a table keyed by index holding the full upper PC as tag
   // and the counter as a plain integer 0..3.
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];

   function automatic int unsigned idx_of(input int unsigned pc);
      return (pc >> 2) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return pc >> (2 + IDX_W);
   endfunction

   function automatic bit m_hit(input int unsigned pc);
      return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
   endfunction

   function automatic bit m_pred(input int unsigned pc);
      return m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
   endtask

   task automatic m_train(input int unsigned pc, input bit t, input int unsigned tgt);
      int unsigned i;
      i = idx_of(pc);
      if (m_hit(pc)) begin
         m_ctr[i] = t ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
         if (t) m_tgt[i] = tgt;
      end else if (t) begin
         m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
      end
   endtask

   // Inputs are set at the falling edge; check combinational outputs, then clock.
   task automatic step();
      bit          e_pt, e_mp;
      int unsigned e_tgt, e_rd;
      #1;
      e_pt  = m_pred(fetch_pc);
      e_tgt = e_pt ? m_tgt[idx_of(fetch_pc)] : 0;
      e_mp  = rst && upd_valid && ((upd_taken != upd_pred_taken) ||
              (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
      e_rd  = !e_mp ? 0 : (upd_taken ? upd_target : upd_pc + 4);
      chk("pred_taken",  64'(pred_taken),  64'(e_pt));
      chk("pred_target", 64'(pred_target), 64'(e_tgt));
      chk("mispredict",  64'(mispredict),  64'(e_mp));
      chk("redirect_pc", 64'(redirect_pc), 64'(e_rd));
      @(posedge clk);
      if (!rst) m_reset();
      else if (upd_valid) m_train(upd_pc, upd_taken, upd_target);
      @(negedge clk);
   endtask

   task automatic upd(input bit v, input int unsigned pc, input bit t, input int unsigned tgt,
                      input bit pt, input int unsigned ptgt);
      upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
      upd_pred_taken = pt; upd_pred_target = ptgt;
   endtask

   initial begin
      rst = 1'b0;
      fetch_pc = 32'h100;
      upd(0, 0, 0, 0, 0, 0);
      m_reset();
      @(negedge clk);
      step();
      rst = 1'b1;

      // reset state
      #1;
      chk("rst_pred_taken",  64'(pred_taken),  64'd0);
      chk("rst_pred_target", 64'(pred_target), 64'd0);
      step();

      // not-taken miss does not allocate
      upd(1, 32'h100, 0, 0, 0, 0); step();
      upd(0, 0, 0, 0, 0, 0);
      #1; chk("nt_no_alloc", 64'(pred_taken), 64'd0);
      step();

      // taken predicted NT: mispredict to 0x200, then allocated
      upd(1, 32'h100, 1, 32'h200, 0, 0);
      #1;
      chk("alloc_mp",    64'(mispredict),  64'd1);
      chk("alloc_redir", 64'(redirect_pc), 64'h200);
      step();
      upd(0, 0, 0, 0, 0, 0);
      #1;
      chk("alloc_pt",  64'(pred_taken),  64'd1);
      chk("alloc_tgt", 64'(pred_target), 64'h200);
      step();

      // saturate, then two not-taken drop the prediction
      for (int k = 0; k < 3; k++) begin upd(1, 32'h100, 1, 32'h200, 1, 32'h200); step(); end
      upd(1, 32'h100, 0, 0, 1, 32'h200); step();
      upd(0, 0, 0, 0, 0, 0);
      #1; chk("hyst_still_t", 64'(pred_taken), 64'd1);
      upd(1, 32'h100, 0, 0, 1, 32'h200); step();
      upd(0, 0, 0, 0, 0, 0);
      #1; chk("hyst_now_nt", 64'(pred_taken), 64'd0);
      step();

      // aliasing: 0x140 shares index 0 with 0x100
      upd(1, 32'h100, 1, 32'h200, 0, 0); step();
      upd(1, 32'h140, 1, 32'h300, 0, 0); step();
      upd(0, 0, 0, 0, 0, 0);
      #1; chk("alias_evicted", 64'(pred_taken), 64'd0);
      fetch_pc = 32'h140;
      #1;
      chk("alias_pt",  64'(pred_taken),  64'd1);
      chk("alias_tgt", 64'(pred_target), 64'h300);
      step();

      // wrong target, wrong direction, and pc+4 wrap
      upd(1, 32'h140, 1, 32'h240, 1, 32'h200);
      #1;
      chk("tgt_mp",    64'(mispredict),  64'd1);
      chk("tgt_redir", 64'(redirect_pc), 64'h240);
      step();
      upd(1, 32'h1FC, 0, 0, 1, 32'h200);
      #1; chk("nt_redir", 64'(redirect_pc), 64'h200);
      step();
      upd(1, 32'hFFFF_FFFC, 0, 0, 1, 32'h10);
      #1;
      chk("wrap_mp",    64'(mispredict),  64'd1);
      chk("wrap_redir", 64'(redirect_pc), 64'd0);
      step();

      // reset while an update is presented
      rst = 1'b0;
      upd(1, 32'h180, 1, 32'h400, 0, 0);
      #1; chk("rst_mp_gated", 64'(mispredict), 64'd0);
      step();
      rst = 1'b1;
      upd(0, 0, 0, 0, 0, 0);
      fetch_pc = 32'h140;
      #1; chk("post_rst_140", 64'(pred_taken), 64'd0);
      fetch_pc = 32'h180;
      #1; chk("post_rst_180", 64'(pred_taken), 64'd0);
      step();

      // randomized traffic on a small PC pool to force hits and aliasing
      for (int n = 0; n < 3000; n++) begin
         int unsigned pc, ftc;
         bit          real_pred;
         pc  = ($urandom_range(0, 3) << (2 + IDX_W)) | ($urandom_range(0, ENTRIES - 1) << 2)
               | $urandom_range(0, 3);
         ftc = ($urandom_range(0, 3) << (2 + IDX_W)) | ($urandom_range(0, ENTRIES - 1) << 2);
         if ($urandom_range(0, 63) == 0) pc = 32'hFFFF_FFFC;
         real_pred = $urandom_range(0, 3) != 0;
         fetch_pc        = ftc;
         upd_valid       = $urandom_range(0, 3) != 0;
         upd_pc          = pc;
         upd_taken       = $urandom_range(0, 1);
         upd_target      = $urandom_range(0, 7) << 4;
         upd_pred_taken  = real_pred ? m_pred(pc) : 1'($urandom_range(0, 1));
         upd_pred_target = (real_pred && m_pred(pc)) ? m_tgt[idx_of(pc)] : ($urandom_range(0, 7) << 4);
         rst             = $urandom_range(0, 199) != 0;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
